// File: rtl/btn_pulse_gen.sv
//------------------------------------------------------------------------------
// Module      : btn_pulse_gen
// Description : Push-button conditioner: 2-flop synchroniser, debounce FSM,
//               press/release strobes, auto-repeat step strobe, step counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_step,
  output logic [7:0] step_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_DB_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_db_last     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
  localparam bit               c_rep_en      = (REPEAT_EN != 0);

  logic             r_s1;
  logic             r_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_step;
  logic [7:0]       r_step_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s  <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s  <= r_s1;
    end
  end

  // Debounce / repeat FSM; all outputs registered, strobes default low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_step    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_step    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_s) begin
            r_state <= ST_DB_PRESS;
            r_cnt   <= '0;
          end
        end
        ST_DB_PRESS: begin
          if (!r_s) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == c_db_last) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_step  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_PRESSED: begin
          if (!r_s) begin
            r_state <= ST_DB_RELEASE;
            r_cnt   <= '0;
          end else if (c_rep_en && (r_cnt == c_delay_last)) begin
            r_state <= ST_REPEAT;
            r_cnt   <= '0;
            r_step  <= 1'b1;
          end else if (r_cnt != c_cnt_max) begin
            // Saturate so a long hold without repeat never wraps the counter.
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_REPEAT: begin
          if (!r_s) begin
            r_state <= ST_DB_RELEASE;
            r_cnt   <= '0;
          end else if (r_cnt == c_period_last) begin
            r_cnt  <= '0;
            r_step <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_DB_RELEASE: begin
          // A bounce back high returns to PRESSED and restarts the repeat delay.
          if (r_s) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == c_db_last) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_cnt <= 8'd0;
    end else if (r_step) begin
      r_step_cnt <= r_step_cnt + 8'd1;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_step    = r_step;
  assign step_cnt    = r_step_cnt;

endmodule

`default_nettype wire
